washing_machine_plant: RTL and testbench
========================================

# washing_machine_plant

Cycle-level emulator of the washer hardware that sits on the far side of `automatic_washing_machine`. It consumes the controller's actuator commands (valves, motor, lock, phase flags) and produces the sensor inputs the controller expects: water full/empty, detergent dispensed, wash and spin timeouts, and door state. It is used in closed-loop simulation and on the FPGA demo board in place of real sensors. It contains:

- a water-level integrator
- a detergent dispenser FSM
- two phase timers
- a door latch model
- sticky fault detection

## Interface

**Parameters**

- `LEVEL_W`, 8, width of water-level counter
- `FULL_LEVEL`, 200, level at or above which `filled` asserts
- `FILL_RATE`, 4, level increment per cycle while filling
- `DRAIN_RATE`, 8, level decrement per cycle while draining
- `DET_CYCLES`, 3, dispense duration in cycles
- `WASH_CYCLES`, 20, motor cycles to `cycle_timeout`
- `SPIN_CYCLES`, 15, spin cycles to `spin_timeout`
- `TMR_W`, 8, timer width; must hold `max(WASH_CYCLES, SPIN_CYCLES, DET_CYCLES)`

**Ports** (clock and reset first)

- `clk` in 1: single clock, all logic on the rising edge
- `reset` in 1: asynchronous, active-low; `reset=0` clears all state immediately
- `door_open_req` in 1: user wants the door open
- `detergent_loaded` in 1: user has filled the detergent drawer
- `door_lock` in 1: controller lock command
- `motor_on` in 1: controller motor command
- `fill_value_on` in 1: controller fill valve command
- `drain_value_on` in 1: controller drain valve command
- `soap_wash` in 1: controller is in soap phase
- `water_wash` in 1: controller is in rinse phase
- `done` in 1: controller cycle-complete flag
- `door_close` out 1: door physically closed
- `filled` out 1: `level >= FULL_LEVEL`
- `drained` out 1: `level == 0`
- `detergent_added` out 1: dispense complete
- `cycle_timeout` out 1: wash/rinse duration elapsed
- `spin_timeout` out 1: spin duration elapsed
- `level` out `LEVEL_W`: current water level
- `fault` out 1: sticky illegal-command flag

## Operation

**Reset values.** While `reset=0`, outputs are `level=0`, `drained=1`, `door_close=0`, and all other outputs are 0. The dispenser FSM is in `D_IDLE` and both timers are 0.

**Level.** The update depends on the valve commands:

- Fill only: `level += FILL_RATE`, saturating at `2^LEVEL_W-1`.
- Drain only: `level -= DRAIN_RATE`, saturating at 0.
- Both valves on: level holds and `fault` is set.
- Neither valve on: level holds.

`filled` and `drained` are registered from the next-level value, so they change on the same edge as `level`.

**Dispenser FSM.** States are `D_IDLE`, `D_DISPENSE` and `D_DONE`.

- `D_IDLE` → `D_DISPENSE` when `soap_wash && filled && detergent_loaded`; the dispense counter loads 0.
- `D_DISPENSE` increments the counter every cycle and moves to `D_DONE` when the counter reaches `DET_CYCLES-1`.
- `D_DONE` drives `detergent_added=1` and returns to `D_IDLE` when `done=1`.
- If `detergent_loaded=0`, the FSM never leaves `D_IDLE`.

**Wash timer.**

- Qualify condition: `motor_on && (soap_wash || water_wash) && !drain_value_on`.
- The timer increments on each qualifying edge and saturates at `WASH_CYCLES`.
- `cycle_timeout = (timer == WASH_CYCLES)`, registered.
- The timer clears when `motor_on=0`, or on a rising edge of `soap_wash` or `water_wash`, so each phase is timed separately.

**Spin timer.**

- Qualify condition: `motor_on && drain_value_on && !fill_value_on`.
- The timer saturates at `SPIN_CYCLES`.
- `spin_timeout = (timer == SPIN_CYCLES)`.
- The timer clears when `motor_on=0`.

**Door.**

- When `door_lock=1`, `door_close` holds its value and `door_open_req` is ignored.
- Otherwise `door_close` becomes `!door_open_req` on the next edge.

**Fault.** `fault` is set by any of the following and is cleared only by reset:

- fill and drain valves on together
- `motor_on && !door_close`
- `door_lock && !door_close`
- `fill_value_on && !door_close`

## Timing

- All outputs are registered.
- Every response appears on the first rising edge after the input is sampled; there are no combinational input-to-output paths.
- Filling from 0 to `FULL_LEVEL` takes `ceil(200/4)` = 50 qualifying edges.
- Draining from 200 to 0 takes 25 edges.
- `detergent_added` rises `DET_CYCLES+1` edges after the trigger condition is first sampled: 1 edge to enter `D_DISPENSE`, plus 3 edges.
- `cycle_timeout` rises on the 20th qualifying edge. `spin_timeout` rises on the 15th qualifying edge.
- Both timeouts fall on the first edge that samples `motor_on=0`.
- Reset asserted mid-operation clears `level` and all timers asynchronously, without waiting for a clock edge. The first edge after release evaluates inputs normally.
- Simultaneous events:
  - When a timer clear and a qualify condition occur on the same edge, the clear wins and the timer goes to 0.
  - When `done` and a dispense trigger occur on the same edge in `D_DONE`, the FSM returns to `D_IDLE`.

## Test plan

1. **Reset and fill.** Hold `reset=0` for 2 cycles, release, then set `fill_value_on=1` with `door_open_req=0` → `level=0`, `drained=1` during reset; `filled=1` with `level=200` on edge 50; after 20 more edges `level=255` and saturates.
2. **Dispense.** With `filled=1`, set `soap_wash=1` and `detergent_loaded=1` → `detergent_added=1` on edge 4; `done=1` clears it next edge. Repeat with `detergent_loaded=0` → `detergent_added` stays 0 for 50 cycles.
3. **Wash timer.** Drive `motor_on=1` and `soap_wash=1` → `cycle_timeout=1` on edge 20; drop `motor_on` → 0 on the next edge. Drive `water_wash` rising → the timer restarts and times out again 20 edges later.
4. **Drain and spin.** From `level=200`, drive `drain_value_on=1` and `motor_on=1` → `drained=1` on edge 25 and `spin_timeout=1` on edge 15.
5. **Door.** With `door_lock=1`, set `door_open_req=1` → `door_close` stays 1. Release the lock → `door_close=0` next edge. Then `motor_on=1` → `fault=1`, which stays set until reset.
6. **Fault and reset mid-operation.** Turn fill and drain valves on together at `level=100` → `level` holds at 100 and `fault=1`. Assert `reset=0` between clock edges → `level=0` and `fault=0` immediately.

Source files
------------

// File: rtl/washing_machine_plant.sv
// Cycle-level washer emulator: turns controller actuator commands into the
// sensor feedback (water level, detergent, phase timeouts, door, fault).
module washing_machine_plant #(
  parameter int LEVEL_W     = 8,
  parameter int FULL_LEVEL  = 200,
  parameter int FILL_RATE   = 4,
  parameter int DRAIN_RATE  = 8,
  parameter int DET_CYCLES  = 3,
  parameter int WASH_CYCLES = 20,
  parameter int SPIN_CYCLES = 15,
  parameter int TMR_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               door_open_req,
  input  logic               detergent_loaded,
  input  logic               door_lock,
  input  logic               motor_on,
  input  logic               fill_value_on,
  input  logic               drain_value_on,
  input  logic               soap_wash,
  input  logic               water_wash,
  input  logic               done,
  output logic               door_close,
  output logic               filled,
  output logic               drained,
  output logic               detergent_added,
  output logic               cycle_timeout,
  output logic               spin_timeout,
  output logic [LEVEL_W-1:0] level,
  output logic               fault
);

  localparam logic [LEVEL_W-1:0] FILL_INC   = LEVEL_W'(FILL_RATE);
  localparam logic [LEVEL_W-1:0] DRAIN_DEC  = LEVEL_W'(DRAIN_RATE);
  localparam logic [LEVEL_W:0]   FULL_THR   = (LEVEL_W+1)'(FULL_LEVEL);
  localparam logic [TMR_W-1:0]   WASH_MAX   = TMR_W'(WASH_CYCLES);
  localparam logic [TMR_W-1:0]   SPIN_MAX   = TMR_W'(SPIN_CYCLES);
  localparam logic [TMR_W-1:0]   DET_LAST   = TMR_W'(DET_CYCLES - 1);
  localparam logic [TMR_W-1:0]   TMR_ONE    = TMR_W'(1);

  typedef enum logic [1:0] {
    D_IDLE     = 2'd0,
    D_DISPENSE = 2'd1,
    D_DONE     = 2'd2
  } det_state_t;

  function automatic logic [LEVEL_W-1:0] sat_add(input logic [LEVEL_W-1:0] a,
                                                 input logic [LEVEL_W-1:0] b);
    logic [LEVEL_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[LEVEL_W] ? {LEVEL_W{1'b1}} : sum[LEVEL_W-1:0];
  endfunction

  function automatic logic [LEVEL_W-1:0] sat_sub(input logic [LEVEL_W-1:0] a,
                                                 input logic [LEVEL_W-1:0] b);
    return (a < b) ? '0 : (a - b);
  endfunction

  function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] t,
                                               input logic [TMR_W-1:0] lim);
    return (t == lim) ? t : (t + TMR_ONE);
  endfunction

  logic [LEVEL_W-1:0] level_next;
  logic               valve_clash;
  det_state_t         det_state, det_state_next;
  logic [TMR_W-1:0]   det_cnt, det_cnt_next;
  logic               det_added_next;
  logic [TMR_W-1:0]   wash_tmr, wash_tmr_next;
  logic [TMR_W-1:0]   spin_tmr, spin_tmr_next;
  logic               soap_prev, water_prev;
  logic               wash_qual, wash_clr, spin_qual;
  logic               door_next, fault_next;

  // Water level integrator: both valves open is a plumbing fault, level holds.
  always_comb begin
    level_next  = level;
    valve_clash = fill_value_on && drain_value_on;
    if (fill_value_on && !drain_value_on) begin
      level_next = sat_add(level, FILL_INC);
    end else if (drain_value_on && !fill_value_on) begin
      level_next = sat_sub(level, DRAIN_DEC);
    end
  end

  // Dispenser FSM next state; the output register follows the next state so
  // detergent_added lines up with the state change.
  always_comb begin
    det_state_next = det_state;
    det_cnt_next   = det_cnt;
    unique case (det_state)
      D_IDLE: begin
        if (soap_wash && filled && detergent_loaded) begin
          det_state_next = D_DISPENSE;
          det_cnt_next   = '0;
        end
      end
      D_DISPENSE: begin
        if (det_cnt == DET_LAST) begin
          det_state_next = D_DONE;
        end else begin
          det_cnt_next = det_cnt + TMR_ONE;
        end
      end
      D_DONE: begin
        if (done) det_state_next = D_IDLE;
      end
      default: det_state_next = D_IDLE;
    endcase
    det_added_next = (det_state_next == D_DONE);
  end

  // A phase-flag rising edge restarts the wash timer so soap and rinse are
  // timed independently; clear has priority over counting.
  always_comb begin
    wash_qual = motor_on && (soap_wash || water_wash) && !drain_value_on;
    wash_clr  = !motor_on || (soap_wash && !soap_prev) || (water_wash && !water_prev);
    spin_qual = motor_on && drain_value_on && !fill_value_on;

    wash_tmr_next = wash_tmr;
    if (wash_clr)       wash_tmr_next = '0;
    else if (wash_qual) wash_tmr_next = sat_inc(wash_tmr, WASH_MAX);

    spin_tmr_next = spin_tmr;
    if (!motor_on)      spin_tmr_next = '0;
    else if (spin_qual) spin_tmr_next = sat_inc(spin_tmr, SPIN_MAX);
  end

  always_comb begin
    door_next  = door_lock ? door_close : !door_open_req;
    fault_next = fault || valve_clash ||
                 (!door_close && (motor_on || door_lock || fill_value_on));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      det_state <= D_IDLE;
      det_cnt   <= '0;
    end else begin
      det_state <= det_state_next;
      det_cnt   <= det_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level           <= '0;
      filled          <= 1'b0;
      drained         <= 1'b1;
      detergent_added <= 1'b0;
      wash_tmr        <= '0;
      spin_tmr        <= '0;
      cycle_timeout   <= 1'b0;
      spin_timeout    <= 1'b0;
      soap_prev       <= 1'b0;
      water_prev      <= 1'b0;
      door_close      <= 1'b0;
      fault           <= 1'b0;
    end else begin
      level           <= level_next;
      filled          <= ({1'b0, level_next} >= FULL_THR);
      drained         <= (level_next == '0);
      detergent_added <= det_added_next;
      wash_tmr        <= wash_tmr_next;
      spin_tmr        <= spin_tmr_next;
      cycle_timeout   <= (wash_tmr_next == WASH_MAX);
      spin_timeout    <= (spin_tmr_next == SPIN_MAX);
      soap_prev       <= soap_wash;
      water_prev      <= water_wash;
      door_close      <= door_next;
      fault           <= fault_next;
    end
  end

endmodule

// File: tb/tb_washing_machine_plant.sv
// Directed closed-loop stimulus for washing_machine_plant with hand-computed
// expectations for level, dispenser, timers, door and fault behaviour.
module tb_washing_machine_plant;

  logic       clk = 1'b0;
  logic       reset;
  logic       door_open_req, detergent_loaded, door_lock, motor_on;
  logic       fill_value_on, drain_value_on, soap_wash, water_wash, done;
  logic       door_close, filled, drained, detergent_added;
  logic       cycle_timeout, spin_timeout, fault;
  logic [7:0] level;

  int n_tests = 0;
  int n_fail  = 0;
  logic seen_det;

  always #5 clk = ~clk;

  washing_machine_plant dut (
    .clk              (clk),
    .reset            (reset),
    .door_open_req    (door_open_req),
    .detergent_loaded (detergent_loaded),
    .door_lock        (door_lock),
    .motor_on         (motor_on),
    .fill_value_on    (fill_value_on),
    .drain_value_on   (drain_value_on),
    .soap_wash        (soap_wash),
    .water_wash       (water_wash),
    .done             (done),
    .door_close       (door_close),
    .filled           (filled),
    .drained          (drained),
    .detergent_added  (detergent_added),
    .cycle_timeout    (cycle_timeout),
    .spin_timeout     (spin_timeout),
    .level            (level),
    .fault            (fault)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b0;
    door_open_req = 1'b0; detergent_loaded = 1'b0; door_lock = 1'b0;
    motor_on = 1'b0; fill_value_on = 1'b0; drain_value_on = 1'b0;
    soap_wash = 1'b0; water_wash = 1'b0; done = 1'b0;

    // Reset values
    tick(2);
    check_eq("rst_level",   int'(level), 0);
    check_eq("rst_drained", int'(drained), 1);
    check_eq("rst_door",    int'(door_close), 0);
    check_eq("rst_filled",  int'(filled), 0);
    check_eq("rst_det",     int'(detergent_added), 0);
    check_eq("rst_cto",     int'(cycle_timeout), 0);
    check_eq("rst_sto",     int'(spin_timeout), 0);
    check_eq("rst_fault",   int'(fault), 0);

    // Door closes, then fill to full and into saturation
    reset = 1'b1;
    tick(1);
    check_eq("door_closes", int'(door_close), 1);
    door_lock = 1'b1; fill_value_on = 1'b1;
    tick(49);
    check_eq("fill49_level",  int'(level), 196);
    check_eq("fill49_filled", int'(filled), 0);
    tick(1);
    check_eq("fill50_level",   int'(level), 200);
    check_eq("fill50_filled",  int'(filled), 1);
    check_eq("fill50_drained", int'(drained), 0);
    tick(13);
    check_eq("fill63_level", int'(level), 252);
    tick(1);
    check_eq("fill64_sat", int'(level), 255);
    tick(6);
    check_eq("fill70_sat",   int'(level), 255);
    check_eq("fill_nofault", int'(fault), 0);
    fill_value_on = 1'b0;

    // Dispense
    soap_wash = 1'b1; detergent_loaded = 1'b1;
    tick(3);
    check_eq("det_edge3", int'(detergent_added), 0);
    tick(1);
    check_eq("det_edge4", int'(detergent_added), 1);
    tick(2);
    check_eq("det_hold", int'(detergent_added), 1);
    done = 1'b1; detergent_loaded = 1'b0;
    tick(1);
    check_eq("det_done_clr", int'(detergent_added), 0);
    done = 1'b0;
    seen_det = 1'b0;
    repeat (50) begin
      tick(1);
      seen_det = seen_det | detergent_added;
    end
    check_eq("det_unloaded", int'(seen_det), 0);

    // Wash timer (soap_wash already high, so no restart on motor start)
    motor_on = 1'b1;
    tick(19);
    check_eq("wash19", int'(cycle_timeout), 0);
    tick(1);
    check_eq("wash20", int'(cycle_timeout), 1);
    tick(3);
    check_eq("wash_sat", int'(cycle_timeout), 1);
    motor_on = 1'b0;
    tick(1);
    check_eq("wash_motor_off", int'(cycle_timeout), 0);
    motor_on = 1'b1;
    tick(10);
    check_eq("wash_partial", int'(cycle_timeout), 0);
    soap_wash = 1'b0; water_wash = 1'b1;
    tick(20);
    check_eq("rinse_restart", int'(cycle_timeout), 0);
    tick(1);
    check_eq("rinse_timeout", int'(cycle_timeout), 1);

    // Drain from saturation to empty without motor
    motor_on = 1'b0; water_wash = 1'b0; drain_value_on = 1'b1;
    tick(1);
    check_eq("cto_fall", int'(cycle_timeout), 0);
    tick(30);
    check_eq("drain31_level",   int'(level), 7);
    check_eq("drain31_drained", int'(drained), 0);
    tick(1);
    check_eq("drain32_level",   int'(level), 0);
    check_eq("drain32_drained", int'(drained), 1);
    tick(1);
    check_eq("drain_floor", int'(level), 0);

    // Refill to 200, then drain with spin
    drain_value_on = 1'b0; fill_value_on = 1'b1;
    tick(50);
    check_eq("refill_level", int'(level), 200);
    fill_value_on = 1'b0; drain_value_on = 1'b1; motor_on = 1'b1;
    tick(14);
    check_eq("spin14", int'(spin_timeout), 0);
    tick(1);
    check_eq("spin15",       int'(spin_timeout), 1);
    check_eq("spin15_level", int'(level), 80);
    tick(9);
    check_eq("drain24_level",   int'(level), 8);
    check_eq("drain24_drained", int'(drained), 0);
    tick(1);
    check_eq("drain25_level",   int'(level), 0);
    check_eq("drain25_drained", int'(drained), 1);
    check_eq("spin_sat",        int'(spin_timeout), 1);
    check_eq("spin_no_wash",    int'(cycle_timeout), 0);
    motor_on = 1'b0;
    tick(1);
    check_eq("spin_fall", int'(spin_timeout), 0);
    drain_value_on = 1'b0;
    check_eq("spin_nofault", int'(fault), 0);

    // Door lock and unlocked-motor fault
    door_open_req = 1'b1;
    tick(2);
    check_eq("door_locked", int'(door_close), 1);
    door_lock = 1'b0;
    tick(1);
    check_eq("door_opens",  int'(door_close), 0);
    check_eq("door_nofault", int'(fault), 0);
    motor_on = 1'b1;
    tick(1);
    check_eq("motor_open_fault", int'(fault), 1);
    motor_on = 1'b0; door_open_req = 1'b0;
    tick(3);
    check_eq("fault_sticky", int'(fault), 1);
    check_eq("door_reclosed", int'(door_close), 1);

    // Valve clash and asynchronous reset mid-cycle
    reset = 1'b0;
    #1;
    check_eq("async_fault_clr", int'(fault), 0);
    check_eq("async_door_clr",  int'(door_close), 0);
    reset = 1'b1;
    tick(1);
    fill_value_on = 1'b1;
    tick(25);
    check_eq("fill25_level", int'(level), 100);
    drain_value_on = 1'b1;
    tick(1);
    check_eq("clash_level", int'(level), 100);
    check_eq("clash_fault", int'(fault), 1);
    tick(1);
    check_eq("clash_hold", int'(level), 100);
    #3;
    reset = 1'b0;
    #1;
    check_eq("mid_rst_level",   int'(level), 0);
    check_eq("mid_rst_fault",   int'(fault), 0);
    check_eq("mid_rst_drained", int'(drained), 1);
    tick(2);
    check_eq("rst_held_level", int'(level), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
